// File: rtl/mult_issue_ctrl.sv
// Issue/capture controller around the combinational Booth multiplier in EX.
// Optional `define MULT_FLUSH_EN adds a flush input that abandons the in-flight operation.
module mult_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
`ifdef MULT_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sign,
  input  logic [TAG_W-1:0] req_rd,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  output logic             mul_sign,
  input  logic [WIDTH-1:0] mul_p,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_p,
  output logic [TAG_W-1:0] resp_rd,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT,
    DONE
  } state_t;

  state_t           state;
  logic [3:0]       count;
  logic [TAG_W-1:0] tag;
  logic             flush_act;
  logic             accept;

`ifdef MULT_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case, so no latch is inferred.
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        req_ready = !flush_act;
        busy      = 1'b0;
      end
      // Retire and accept share one edge, so a new request costs no bubble.
      DONE:    req_ready = resp_ready && !flush_act;
      default: ;
    endcase
  end

  assign accept = req_valid && req_ready;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      tag        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_sign   <= 1'b0;
      resp_valid <= 1'b0;
      resp_p     <= '0;
      resp_rd    <= '0;
    end else if (flush_act && state != IDLE) begin
      // Operands stay on the multiplier; only the result is dropped.
      state      <= IDLE;
      count      <= '0;
      resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (state == DONE && resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
          if (accept) begin
            mul_a    <= req_a;
            mul_b    <= req_b;
            mul_sign <= req_sign;
            tag      <= req_rd;
            if (LATENCY == 1) begin
              state <= CAPT;
            end else begin
              state <= WAIT;
              count <= 4'(LATENCY - 2);
            end
          end
        end
        WAIT: begin
          if (count == '0) state <= CAPT;
          else             count <= count - 4'd1;
        end
        CAPT: begin
          resp_p     <= mul_p;
          resp_rd    <= tag;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Self-checking bench for mult_issue_ctrl: directed vector table, random traffic
// against a transaction-level model, and hand-written backpressure/reset/flush sequences.
module tb_mult_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = 2;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
`ifdef MULT_FLUSH_EN
  logic             flush;
`endif
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_sign;
  logic [TAG_W-1:0] req_rd;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_sign;
  logic [WIDTH-1:0] mul_p;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_p;
  logic [TAG_W-1:0] resp_rd;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Stand-in for the Booth multiplier: the low product word is sign-independent.
  assign mul_p = mul_a * mul_b;

  mult_issue_ctrl #(.WIDTH(WIDTH), .LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef MULT_FLUSH_EN
    .flush      (flush),
`endif
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sign   (req_sign),
    .req_rd     (req_rd),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_sign   (mul_sign),
    .mul_p      (mul_p),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_p     (resp_p),
    .resp_rd    (resp_rd),
    .busy       (busy)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sign;
    logic [TAG_W-1:0] rd;
    logic [WIDTH-1:0] exp_p;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_prod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic s);
    logic [63:0] full;
    if (s) full = 64'($signed(a)) * 64'($signed(b));
    else   full = {32'b0, a} * {32'b0, b};
    return full[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One isolated operation with resp_ready high; checks exact response timing.
  task automatic run_op(input vec_t v);
    @(negedge clk);
    req_valid = 1'b1; req_a = v.a; req_b = v.b; req_sign = v.sign; req_rd = v.rd;
    resp_ready = 1'b1;
    #1;
    check("op_req_ready", req_ready, 1);
    check("op_idle_busy", busy, 0);
    @(posedge clk);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("op_wait_valid", resp_valid, 0);
      check("op_wait_busy", busy, 1);
      check("op_wait_ready", req_ready, 0);
      check("op_hold_a", mul_a, v.a);
      check("op_hold_b", mul_b, v.b);
      check("op_hold_sign", mul_sign, v.sign);
    end
    @(negedge clk); #1;
    check("op_resp_valid", resp_valid, 1);
    check("op_resp_p", resp_p, v.exp_p);
    check("op_resp_rd", resp_rd, v.rd);
    @(negedge clk); #1;
    check("op_retire_valid", resp_valid, 0);
    check("op_retire_busy", busy, 0);
  endtask

  task automatic wait_resp(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic             pending, exp_rv, exp_rr, do_acc, do_ret, consumed;
    int               cyc, ready_cyc;
    logic [WIDTH-1:0] m_a, m_b, m_p;
    logic [TAG_W-1:0] m_rd;

    vecs[0] = '{a: 32'd7,         b: 32'd6, sign: 1'b0, rd: 5'd3,  exp_p: 32'd42};
    vecs[1] = '{a: 32'hFFFF_FFFD, b: 32'd5, sign: 1'b1, rd: 5'd7,  exp_p: 32'hFFFF_FFF1};
    vecs[2] = '{a: 32'hFFFF_FFFD, b: 32'd5, sign: 1'b0, rd: 5'd8,  exp_p: 32'hFFFF_FFF1};
    vecs[3] = '{a: 32'h0001_0000, b: 32'h0001_0000, sign: 1'b0, rd: 5'd31, exp_p: 32'd0};
    vecs[4] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, sign: 1'b1, rd: 5'd0,  exp_p: 32'd1};

    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sign = 1'b0;
    req_rd = '0; resp_ready = 1'b0;
`ifdef MULT_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_sign", mul_sign, 0);
    check("rst_resp_p", resp_p, 0);
    check("rst_resp_rd", resp_rd, 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Random traffic against a transaction model: a result is due LAT edges after accept.
    pending = 1'b0; cyc = 0; ready_cyc = 0; consumed = 1'b0;
    m_a = '0; m_b = '0; m_p = '0; m_rd = '0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (consumed) begin
        req_valid = 1'b0;
        consumed  = 1'b0;
      end
      if (!req_valid && $urandom_range(0, 2) != 0) begin
        req_valid = 1'b1;
        req_a = pick(); req_b = pick();
        req_sign = 1'($urandom_range(0, 1));
        req_rd = 5'($urandom);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rv = pending && (cyc >= ready_cyc);
      exp_rr = !pending || (exp_rv && resp_ready);
      check("rnd_resp_valid", resp_valid, exp_rv);
      check("rnd_req_ready", req_ready, exp_rr);
      check("rnd_busy", busy, pending);
      if (exp_rv) begin
        check("rnd_resp_p", resp_p, m_p);
        check("rnd_resp_rd", resp_rd, m_rd);
      end
      if (pending) begin
        check("rnd_hold_a", mul_a, m_a);
        check("rnd_hold_b", mul_b, m_b);
      end
      do_acc = req_valid && exp_rr;
      do_ret = exp_rv && resp_ready;
      @(posedge clk);
      cyc++;
      if (do_ret) pending = 1'b0;
      if (do_acc) begin
        pending = 1'b1; ready_cyc = cyc + LAT;
        m_a = req_a; m_b = req_b; m_rd = req_rd;
        m_p = ref_prod(req_a, req_b, req_sign);
        consumed = 1'b1;
      end
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    #1;
    check("drain_busy", busy, 0);

    // Backpressure, then retire and accept 3*4 on the same edge.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'h0001_0000; req_b = 32'h0001_0000; req_sign = 1'b0;
    req_rd = 5'd21; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp("bp_resp_seen");
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd3; req_b = 32'd4; req_rd = 5'd9;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_valid", resp_valid, 1);
      check("bp_resp_p", resp_p, 0);
      check("bp_resp_rd", resp_rd, 21);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_hold_a", mul_a, 32'h0001_0000);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    check("b2b_req_ready", req_ready, 1);
    @(posedge clk);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      check("b2b_wait_valid", resp_valid, 0);
      check("b2b_busy", busy, 1);
    end
    @(negedge clk); #1;
    check("b2b_valid", resp_valid, 1);
    check("b2b_resp_p", resp_p, 12);
    check("b2b_resp_rd", resp_rd, 9);
    @(negedge clk); #1;
    check("b2b_idle", busy, 0);

    // Reset during WAIT discards the operation entirely.
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd11; req_b = 32'd13; req_rd = 5'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    #1;
    check("mid_wait_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rstw_valid", resp_valid, 0);
    check("rstw_busy", busy, 0);
    check("rstw_ready", req_ready, 1);
    check("rstw_mul_a", mul_a, 0);
    check("rstw_mul_b", mul_b, 0);
    for (int i = 0; i < 2 * LAT + 2; i++) begin
      @(negedge clk); #1;
      check("rstw_no_resp", resp_valid, 0);
    end

`ifdef MULT_FLUSH_EN
    @(negedge clk);
    req_valid = 1'b1; req_a = 32'd7; req_b = 32'd6; req_rd = 5'd2; resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp("fl_resp_seen");
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("fl_req_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_valid", resp_valid, 0);
    check("fl_busy", busy, 0);
    check("fl_hold_a", mul_a, 7);
    run_op('{a: 32'd2, b: 32'd9, sign: 1'b0, rd: 5'd17, exp_p: 32'd18});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
